// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronizer, oversampled bit timing with a 3-sample
// majority vote at mid-bit, optional even/odd parity and stop-bit checking.
module uart_rx #(
    parameter int DATA_WIDTH = 8,
    parameter int OVERSAMPLE = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  DATA_VALID,
    output logic                  PAR_ERR,
    output logic                  STP_ERR,
    output logic                  Busy
);

    localparam int CW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [CW-1:0] EDGE_ONE  = CW'(1);
    localparam logic [CW-1:0] EDGE_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] EDGE_MLO  = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] EDGE_MID  = CW'(OVERSAMPLE / 2);
    localparam logic [CW-1:0] EDGE_MHI  = CW'(OVERSAMPLE / 2 + 1);
    localparam logic [BW-1:0] BIT_ONE   = BW'(1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                  state;
    logic [CW-1:0]           edge_cnt;
    logic [BW-1:0]           bit_cnt;
    logic                    par_en_l;
    logic                    par_typ_l;
    logic                    par_fail;

    logic                    rx_p0;
    logic                    rx_p1;
    logic                    rx_s;
    logic                    samp_a;
    logic                    samp_b;
    logic                    voted;
    logic                    vote_edge;
    logic                    last_edge;
    logic [DATA_WIDTH-1:0]   shift_reg;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Stage p0/p1: metastability synchronizer, idles high out of reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_p0 <= 1'b1;
            rx_p1 <= 1'b1;
        end else begin
            rx_p0 <= RX_IN;
            rx_p1 <= rx_p0;
        end
    end

    assign rx_s      = rx_p1;
    assign vote_edge = (edge_cnt == EDGE_MHI);
    assign last_edge = (edge_cnt == EDGE_LAST);
    assign voted     = maj3(samp_a, samp_b, rx_s);

    // Datapath: first two vote samples and the LSB-first shift register
    always_ff @(posedge clk) begin
        if (edge_cnt == EDGE_MLO) begin
            samp_a <= rx_s;
        end
        if (edge_cnt == EDGE_MID) begin
            samp_b <= rx_s;
        end
        if (state == DATA && vote_edge) begin
            shift_reg <= {voted, shift_reg[DATA_WIDTH-1:1]};
        end
    end

    // Frame control and registered strobes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            edge_cnt   <= '0;
            bit_cnt    <= '0;
            par_en_l   <= 1'b0;
            par_typ_l  <= 1'b0;
            par_fail   <= 1'b0;
            P_DATA     <= '0;
            DATA_VALID <= 1'b0;
            PAR_ERR    <= 1'b0;
            STP_ERR    <= 1'b0;
            Busy       <= 1'b0;
        end else begin
            DATA_VALID <= 1'b0;
            PAR_ERR    <= 1'b0;
            STP_ERR    <= 1'b0;

            if (state != IDLE) begin
                edge_cnt <= last_edge ? '0 : edge_cnt + EDGE_ONE;
            end

            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        // This edge is sample 0 of the start bit
                        state     <= START;
                        edge_cnt  <= EDGE_ONE;
                        bit_cnt   <= '0;
                        par_en_l  <= PAR_EN;
                        par_typ_l <= PAR_TYP;
                        par_fail  <= 1'b0;
                        Busy      <= 1'b1;
                    end
                end

                START: begin
                    if (vote_edge && voted) begin
                        state    <= IDLE;
                        edge_cnt <= '0;
                        Busy     <= 1'b0;
                    end else if (last_edge) begin
                        state <= DATA;
                    end
                end

                DATA: begin
                    if (last_edge) begin
                        if (bit_cnt == BIT_LAST) begin
                            bit_cnt <= '0;
                            state   <= par_en_l ? PARITY : STOP;
                        end else begin
                            bit_cnt <= bit_cnt + BIT_ONE;
                        end
                    end
                end

                PARITY: begin
                    if (vote_edge) begin
                        par_fail <= (voted != ((^shift_reg) ^ par_typ_l));
                    end
                    if (last_edge) begin
                        state <= STOP;
                    end
                end

                STOP: begin
                    // Resolve at mid stop bit: half a bit of slack for the next start
                    if (vote_edge) begin
                        state    <= IDLE;
                        edge_cnt <= '0;
                        Busy     <= 1'b0;
                        if (voted && !par_fail) begin
                            P_DATA     <= shift_reg;
                            DATA_VALID <= 1'b1;
                        end else begin
                            PAR_ERR <= par_fail;
                            STP_ERR <= !voted;
                        end
                    end
                end

                default: begin
                    state    <= IDLE;
                    edge_cnt <= '0;
                    Busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: random and directed serial frames, checked every cycle
// against a frame-level model computed from the recorded line history.
module tb_uart_rx;

    localparam int OS   = 8;
    localparam int DW   = 8;
    localparam int MAXC = 40000;

    logic          clk = 1'b0;
    logic          reset;
    logic          RX_IN;
    logic          PAR_EN;
    logic          PAR_TYP;
    logic [DW-1:0] P_DATA;
    logic          DATA_VALID;
    logic          PAR_ERR;
    logic          STP_ERR;
    logic          Busy;

    uart_rx #(.DATA_WIDTH(DW), .OVERSAMPLE(OS)) dut (
        .clk        (clk),
        .reset      (reset),
        .RX_IN      (RX_IN),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .P_DATA     (P_DATA),
        .DATA_VALID (DATA_VALID),
        .PAR_ERR    (PAR_ERR),
        .STP_ERR    (STP_ERR),
        .Busy       (Busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Line history and reference model
    int            cyc = 0;
    bit            line [0:MAXC-1];
    int            rst_edge = 0;
    bit            rst_armed = 1'b1;
    bit            in_frame = 1'b0;
    int            e0 = 0;
    bit            l_pen, l_ptyp;
    logic [DW-1:0] m_dat;
    bit            m_pfail, m_stop;
    logic          exp_dv = 1'b0, exp_pe = 1'b0, exp_se = 1'b0, exp_busy = 1'b0;
    logic [DW-1:0] exp_pd = '0;

    function automatic bit rxs(input int n);
        if (n - 2 < rst_edge) return 1'b1;
        return line[n-2];
    endfunction

    function automatic bit bitval(input int e, input int b);
        int ones = 0;
        for (int j = OS/2 - 1; j <= OS/2 + 1; j++) ones += int'(rxs(e + b*OS + j));
        return ones >= 2;
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (cyc < MAXC) line[cyc] = RX_IN;
        exp_dv = 1'b0;
        exp_pe = 1'b0;
        exp_se = 1'b0;
        if (!reset) begin
            in_frame  = 1'b0;
            exp_busy  = 1'b0;
            exp_pd    = '0;
            rst_armed = 1'b1;
        end else begin
            if (rst_armed) begin
                rst_edge  = cyc;
                rst_armed = 1'b0;
            end
            if (!in_frame) begin
                if (rxs(cyc) == 1'b0) begin
                    in_frame = 1'b1;
                    e0       = cyc;
                    l_pen    = PAR_EN;
                    l_ptyp   = PAR_TYP;
                    exp_busy = 1'b1;
                end
            end else if (cyc == e0 + OS/2 + 1 && bitval(e0, 0)) begin
                in_frame = 1'b0;
                exp_busy = 1'b0;
            end else if (cyc == e0 + (1 + DW + int'(l_pen))*OS + OS/2 + 1) begin
                for (int i = 0; i < DW; i++) m_dat[i] = bitval(e0, 1 + i);
                m_pfail = l_pen && (bitval(e0, 1 + DW) != ((^m_dat) ^ l_ptyp));
                m_stop  = bitval(e0, 1 + DW + int'(l_pen));
                if (m_stop && !m_pfail) begin
                    exp_dv = 1'b1;
                    exp_pd = m_dat;
                end else begin
                    exp_pe = m_pfail;
                    exp_se = !m_stop;
                end
                in_frame = 1'b0;
                exp_busy = 1'b0;
            end
        end
    end

    // Per-cycle compare plus event monitors
    int            cnt_dv = 0, cnt_pe = 0, cnt_se = 0;
    int            last_dv_edge = -1, last_pe_edge = -1, last_se_edge = -1;
    bit            busy_seen = 1'b0;
    bit            prev_strobe = 1'b0;
    logic [DW-1:0] dv_q [$];

    always @(negedge clk) begin
        bit strobe;
        strobe = DATA_VALID | PAR_ERR | STP_ERR;
        n_vec++;
        if ({DATA_VALID, PAR_ERR, STP_ERR, Busy, P_DATA} !== {exp_dv, exp_pe, exp_se, exp_busy, exp_pd}
            || (strobe && prev_strobe)) begin
            n_err++;
            $display("FAIL cycle_%0d dv/pe/se/busy/pdata got %b%b%b%b/%h want %b%b%b%b/%h back_to_back=%b",
                     cyc, DATA_VALID, PAR_ERR, STP_ERR, Busy, P_DATA,
                     exp_dv, exp_pe, exp_se, exp_busy, exp_pd, strobe && prev_strobe);
        end
        prev_strobe = strobe;
        if (DATA_VALID === 1'b1) begin cnt_dv++; last_dv_edge = cyc; dv_q.push_back(P_DATA); end
        if (PAR_ERR === 1'b1) begin cnt_pe++; last_pe_edge = cyc; end
        if (STP_ERR === 1'b1) begin cnt_se++; last_se_edge = cyc; end
        if (Busy === 1'b1) busy_seen = 1'b1;
    end

    task automatic check(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", name, act, act, req, req);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // Drives one frame; returns early with reset asserted if abort_bit is reached
    task automatic send_frame(input logic [DW-1:0] d, input bit pen, input bit ptyp,
                              input bit par_flip, input bit stop_v, input int spike_bit,
                              input int spike_j, input int abort_bit, input bit scramble,
                              output int start_cyc);
        bit bits [0:DW+2];
        int nb;
        bits[0] = 1'b0;
        for (int i = 0; i < DW; i++) bits[1+i] = d[i];
        if (pen) bits[1+DW] = (^d) ^ ptyp ^ par_flip;
        nb = 2 + DW + int'(pen);
        bits[nb-1] = stop_v;
        PAR_EN  = pen;
        PAR_TYP = ptyp;
        start_cyc = cyc;
        for (int b = 0; b < nb; b++) begin
            for (int j = 0; j < OS; j++) begin
                RX_IN = (b == spike_bit && j == spike_j) ? ~bits[b] : bits[b];
                if (b == abort_bit && j == OS/2) begin
                    reset = 1'b0;
                    #1;
                    check("reset_abort_outputs", int'({DATA_VALID, PAR_ERR, STP_ERR, Busy, P_DATA}), 0);
                    RX_IN = 1'b1;
                    return;
                end
                if (scramble && b == 2 && j == 0) begin
                    PAR_EN  = $urandom_range(0, 1);
                    PAR_TYP = $urandom_range(0, 1);
                end
                wait_cyc(1);
            end
        end
        RX_IN = 1'b1;
    endtask

    int sc, dv0, pe0, se0;

    initial begin
        reset   = 1'b0;
        RX_IN   = 1'b1;
        PAR_EN  = 1'b0;
        PAR_TYP = 1'b0;
        wait_cyc(4);
        check("reset_outputs", int'({DATA_VALID, PAR_ERR, STP_ERR, Busy, P_DATA}), 0);
        reset = 1'b1;
        wait_cyc(6);

        // Back-to-back 0x00 then 0xFF, no parity
        dv_q.delete(); pe0 = cnt_pe; se0 = cnt_se;
        send_frame(8'h00, 0, 0, 0, 1, -1, 0, -1, 0, sc);
        send_frame(8'hFF, 0, 0, 0, 1, -1, 0, -1, 0, sc);
        wait_cyc(4);
        check("b2b_count", dv_q.size(), 2);
        check("b2b_first", dv_q.size() > 0 ? int'(dv_q[0]) : -1, 8'h00);
        check("b2b_second", dv_q.size() > 1 ? int'(dv_q[1]) : -1, 8'hFF);
        check("b2b_errors", (cnt_pe - pe0) + (cnt_se - se0), 0);

        // Even parity 0xA5, good then flipped parity bit
        send_frame(8'hA5, 1, 0, 0, 1, -1, 0, -1, 0, sc);
        wait_cyc(4);
        check("par_ok_dv_edge", last_dv_edge, sc + 3 + 85);
        check("par_ok_pdata", int'(P_DATA), 8'hA5);
        dv0 = cnt_dv; pe0 = cnt_pe;
        send_frame(8'hA5, 1, 0, 1, 1, -1, 0, -1, 0, sc);
        wait_cyc(4);
        check("par_bad_pe", cnt_pe - pe0, 1);
        check("par_bad_pe_edge", last_pe_edge, sc + 3 + 85);
        check("par_bad_no_dv", cnt_dv - dv0, 0);
        check("par_bad_pdata_hold", int'(P_DATA), 8'hA5);

        // Stop bit driven low
        dv0 = cnt_dv; se0 = cnt_se;
        send_frame(8'h3C, 0, 0, 0, 0, -1, 0, -1, 0, sc);
        wait_cyc(4);
        check("stop_err_edge", last_se_edge, sc + 3 + 77);
        check("stop_err_count", cnt_se - se0, 1);
        check("stop_err_no_dv", cnt_dv - dv0, 0);
        check("stop_err_pdata_hold", int'(P_DATA), 8'hA5);

        // Two-clock glitch on an idle line, then a clean frame
        busy_seen = 1'b0; dv0 = cnt_dv; pe0 = cnt_pe; se0 = cnt_se;
        RX_IN = 1'b0;
        wait_cyc(2);
        RX_IN = 1'b1;
        wait_cyc(20);
        check("glitch_busy_rose", int'(busy_seen), 1);
        check("glitch_busy_fell", int'(Busy), 0);
        check("glitch_no_strobes", (cnt_dv - dv0) + (cnt_pe - pe0) + (cnt_se - se0), 0);
        send_frame(8'h5A, 0, 0, 0, 1, -1, 0, -1, 0, sc);
        wait_cyc(4);
        check("after_glitch_pdata", int'(P_DATA), 8'h5A);

        // One-clock spike at mid-sample of data bit 3 (frame bit 4)
        dv0 = cnt_dv;
        send_frame(8'h81, 0, 0, 0, 1, 4, OS/2, -1, 0, sc);
        wait_cyc(4);
        check("spike_pdata", int'(P_DATA), 8'h81);
        check("spike_dv", cnt_dv - dv0, 1);

        // Reset during data bit 4, then a clean frame
        send_frame(8'hF0, 0, 0, 0, 1, -1, 0, 5, 0, sc);
        wait_cyc(3);
        reset = 1'b1;
        wait_cyc(4);
        send_frame(8'hC3, 0, 0, 0, 1, -1, 0, -1, 0, sc);
        wait_cyc(4);
        check("post_reset_pdata", int'(P_DATA), 8'hC3);

        // Break: line held low
        dv0 = cnt_dv; se0 = cnt_se;
        RX_IN = 1'b0;
        wait_cyc(3 * 80 + 20);
        check("break_stp_err_ge3", int'((cnt_se - se0) >= 3), 1);
        check("break_no_dv", cnt_dv - dv0, 0);
        RX_IN = 1'b1;
        wait_cyc(100);

        // Randomized traffic
        for (int f = 0; f < 120; f++) begin
            int gap, sbit;
            bit pen;
            if ($urandom_range(0, 5) == 0) begin
                RX_IN = 1'b0;
                wait_cyc($urandom_range(1, OS));
                RX_IN = 1'b1;
                wait_cyc(2 * OS);
            end
            pen  = $urandom_range(0, 1);
            sbit = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 9 + int'(pen))) : -1;
            send_frame(DW'($urandom), pen, $urandom_range(0, 1),
                       $urandom_range(0, 7) == 0, $urandom_range(0, 7) != 0,
                       sbit, $urandom_range(0, OS - 1), -1, $urandom_range(0, 1), sc);
            gap = $urandom_range(0, 12);
            if (gap > 0) wait_cyc(gap);
        end
        wait_cyc(120);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial-to-parallel UART receiver, the receive-side counterpart of the team's UART transmitter. It uses the same frame format: start bit 0, DATA_WIDTH data bits LSB first, optional parity bit, one stop bit 1. The block oversamples RX_IN, takes a 3-sample majority vote at mid-bit, checks parity and the stop bit, and presents each good byte on P_DATA with a one-cycle DATA_VALID strobe. It sits between the chip pad (or the transmitter's TX_OUT in loopback) and the byte-level consumer.

## Interface
- DATA_WIDTH, 8, data bits per frame.
- OVERSAMPLE, 8, clocks per bit period; even, ≥ 4.
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- RX_IN  input  1  serial line, idle high.
- PAR_EN  input  1  1 = parity bit present after the data bits.
- PAR_TYP  input  1  0 = even parity, 1 = odd parity.
- P_DATA  output  DATA_WIDTH  last correctly received word.
- DATA_VALID  output  1  one-cycle strobe, P_DATA updated.
- PAR_ERR  output  1  one-cycle strobe, parity mismatch.
- STP_ERR  output  1  one-cycle strobe, stop bit sampled 0.
- Busy  output  1  high while a frame is being received.

## Operation
- RX_IN passes through a 2-flop synchronizer; call the output rx_s. Both flops reset to 1.
- FSM states: IDLE, START, DATA, PARITY, STOP. An edge counter runs 0..OVERSAMPLE-1 and a bit counter runs 0..DATA_WIDTH-1.
- IDLE: when rx_s == 0, go to START. This edge is E0. Latch PAR_EN and PAR_TYP at E0. Mid-frame changes to PAR_EN or PAR_TYP are ignored.
- Sample index j of frame bit b = rx_s at edge E0 + b·OVERSAMPLE + j. Bit 0 is the start bit.
- Bit value = majority of sample indices OVERSAMPLE/2-1, OVERSAMPLE/2, OVERSAMPLE/2+1.
- START: if the majority is 1, treat it as a glitch. Return to IDLE at the vote edge with no strobes. Otherwise proceed to DATA at the end of the bit (edge counter wrap).
- DATA: shift each voted bit in LSB first. After DATA_WIDTH bits, go to PARITY if the latched PAR_EN is 1, else go to STOP.
- PARITY: expected bit = XOR of data bits, XORed with PAR_TYP. A mismatch sets an internal parity-fail flag. The check is resolved at the stop vote.
- STOP: at the stop-bit vote edge, produce the strobes below and return to IDLE on the same edge. This leaves half a bit of margin for back-to-back frames.
  - good stop bit and parity ok: P_DATA <= shift register, DATA_VALID = 1.
  - parity fail: PAR_ERR = 1, DATA_VALID = 0, P_DATA holds.
  - stop bit = 0: STP_ERR = 1, DATA_VALID = 0, P_DATA holds.
  - parity fail and stop bit = 0 together: PAR_ERR and STP_ERR both high in the same cycle.
- A line held low (break) yields repeated all-zero frames, each with STP_ERR. No DATA_VALID is produced.
- Busy = 1 from E0 through the stop vote edge. It also drops at a glitch abort.

## Timing
- Reset values: P_DATA = 0, DATA_VALID = PAR_ERR = STP_ERR = Busy = 0, FSM = IDLE, counters = 0.
- Reset asserted mid-frame aborts immediately, with no strobe. The next frame needs a fresh falling edge after reset release.
- E0 = 2 edges after the first edge that samples RX_IN low.
- Stop bit index k = 1 + DATA_WIDTH + PAR_EN.
- Strobes and the new P_DATA are visible for exactly one clock starting at edge E0 + k·OVERSAMPLE + OVERSAMPLE/2 + 1.
- Defaults (OVERSAMPLE = 8, DATA_WIDTH = 8): E0+77 without parity, E0+85 with parity.
- Strobes are never asserted on consecutive cycles.
- The earliest next E0 is the edge after the strobe edge.

## Test plan
- Reset, then drive 0x00 then 0xFF, each frame 8 clocks/bit, no parity, with no idle gap between frames → two DATA_VALID pulses; P_DATA 0x00, then 0xFF; no errors.
- Drive 0xA5, PAR_EN = 1, PAR_TYP = 0 (even), parity bit 0 → DATA_VALID at E0+85, P_DATA = 0xA5. Repeat with the parity bit driven 1 → PAR_ERR only, P_DATA stays 0xA5.
- Drive 0x3C with the stop bit driven 0 → STP_ERR at E0+77, DATA_VALID = 0, P_DATA unchanged.
- Drive a 2-clock low pulse on an idle line → Busy rises and then falls with no strobes. Then drive a clean 0x5A → P_DATA = 0x5A.
- Drive a 1-clock inverted spike at sample index OVERSAMPLE/2 of data bit 3 of 0x81 → majority vote rejects the spike; P_DATA = 0x81.
- Assert reset at data bit 4 of a frame → all outputs 0 immediately. After release, a clean 0xC3 frame is received correctly.
